// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and control encodings for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

    localparam int DEF_MDU_LAT = 4;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EX_BUSY  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic memwb_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_bubble;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF     = 9'b00000_0000;
    localparam ctrl_t CTRL_ADVANCE = 9'b11111_0000;
    // EX is occupied: front end frozen, EX/MEM captures a bubble behind it
    localparam ctrl_t CTRL_MDU     = 9'b00011_0010;
    // MEM is waiting: only MEM/WB advances, and it captures a bubble
    localparam ctrl_t CTRL_MEM     = 9'b00001_0001;

    function automatic ctrl_t id_stage_ctrl(input logic load_use, input logic branch);
        ctrl_t c;
        c = CTRL_ADVANCE;
        if (load_use) begin
            c.pc_write    = 1'b0;
            c.ifid_write  = 1'b0;
            c.idex_bubble = 1'b1;
        end else if (branch) begin
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stage-register controls between datapath and sequencer
interface pipeline_ctrl_if;

    logic       idex_memrd_i;
    logic [4:0] idex_rt_i;
    logic [4:0] ifid_rs_i;
    logic [4:0] ifid_rt_i;
    logic       branch_taken_i;
    logic       mdu_start_i;
    logic       mem_req_i;
    logic       mem_ack_i;

    logic       pc_write_o;
    logic       ifid_write_o;
    logic       idex_write_o;
    logic       exmem_write_o;
    logic       memwb_write_o;
    logic       ifid_flush_o;
    logic       idex_bubble_o;
    logic       exmem_bubble_o;
    logic       memwb_bubble_o;

    modport master (
        output idex_memrd_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
        output branch_taken_i, mdu_start_i, mem_req_i, mem_ack_i,
        input  pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o,
        input  ifid_flush_o, idex_bubble_o, exmem_bubble_o, memwb_bubble_o
    );

    modport slave (
        input  idex_memrd_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
        input  branch_taken_i, mdu_start_i, mem_req_i, mem_ack_i,
        output pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o,
        output ifid_flush_o, idex_bubble_o, exmem_bubble_o, memwb_bubble_o
    );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// rtl/pipeline_ctrl_load_use_detect.sv - combinational load-use hazard between the EX load and the ID consumer
module load_use_detect (
    input  logic       memrd_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       hazard_o
);

    // $zero is never a real producer, so a load into r0 cannot create a hazard
    assign hazard_o = memrd_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = DEF_MDU_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    pipeline_ctrl_if.slave   bus,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int MCW = $clog2(MDU_LAT);
    // The entry cycle and the release cycle are both part of the MDU occupancy
    localparam logic [MCW-1:0] MDU_LOAD = MCW'(MDU_LAT - 2);

    state_t           state_q, state_d;
    logic [MCW-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    ctrl_t            ctrl, ctrl_out;
    logic             load_use;
    logic             mem_stall;

    load_use_detect u_load_use_detect (
        .memrd_i  (bus.idex_memrd_i),
        .ex_rt_i  (bus.idex_rt_i),
        .id_rs_i  (bus.ifid_rs_i),
        .id_rt_i  (bus.ifid_rt_i),
        .hazard_o (load_use)
    );

    assign mem_stall = bus.mem_req_i && !bus.mem_ack_i;

    always_comb begin
        ctrl      = CTRL_ADVANCE;
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    ctrl    = CTRL_MEM;
                    state_d = ST_MEM_WAIT;
                end else if (bus.mdu_start_i) begin
                    ctrl      = CTRL_MDU;
                    mdu_cnt_d = MDU_LOAD;
                    state_d   = ST_EX_BUSY;
                end else begin
                    ctrl = id_stage_ctrl(load_use, bus.branch_taken_i);
                end
            end
            ST_EX_BUSY: begin
                if (mdu_cnt_q != '0) begin
                    ctrl      = CTRL_MDU;
                    mdu_cnt_d = mdu_cnt_q - MCW'(1);
                end else begin
                    // mdu_start_i is still high for the retiring op, so only ID hazards apply
                    ctrl    = id_stage_ctrl(load_use, bus.branch_taken_i);
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.mem_ack_i) begin
                    ctrl = CTRL_MEM;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign ctrl_out = (rst_n_i && start_i) ? ctrl : CTRL_OFF;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (start_i) begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            if (!ctrl_out.pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_write_o     = ctrl_out.pc_write;
    assign bus.ifid_write_o   = ctrl_out.ifid_write;
    assign bus.idex_write_o   = ctrl_out.idex_write;
    assign bus.exmem_write_o  = ctrl_out.exmem_write;
    assign bus.memwb_write_o  = ctrl_out.memwb_write;
    assign bus.ifid_flush_o   = ctrl_out.ifid_flush;
    assign bus.idex_bubble_o  = ctrl_out.idex_bubble;
    assign bus.exmem_bubble_o = ctrl_out.exmem_bubble;
    assign bus.memwb_bubble_o = ctrl_out.memwb_bubble;

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        start2;
    logic [1:0]  state_o, state2;
    logic [15:0] stall_cnt_o;
    logic [1:0]  stall_cnt2;

    pipeline_ctrl_if bus ();
    pipeline_ctrl_if bus2 ();

    pipeline_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .bus         (bus),
        .state_o     (state_o),
        .stall_cnt_o (stall_cnt_o)
    );

    pipeline_ctrl #(.MDU_LAT(2), .CNT_W(2)) dut_sat (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start2),
        .bus         (bus2),
        .state_o     (state2),
        .stall_cnt_o (stall_cnt2)
    );

    always #5 clk_i = ~clk_i;

    // {pc, ifid, idex, exmem, memwb} write enables
    localparam logic [4:0] EN_ALL = 5'b11111;
    localparam logic [4:0] EN_LU  = 5'b00111;
    localparam logic [4:0] EN_MDU = 5'b00011;
    localparam logic [4:0] EN_MEM = 5'b00001;
    localparam logic [4:0] EN_OFF = 5'b00000;
    // {ifid_flush, idex_bubble, exmem_bubble, memwb_bubble}
    localparam logic [3:0] B_NONE = 4'b0000;
    localparam logic [3:0] B_BR   = 4'b1000;
    localparam logic [3:0] B_LU   = 4'b0100;
    localparam logic [3:0] B_MDU  = 4'b0010;
    localparam logic [3:0] B_MEM  = 4'b0001;
    // stimulus {idex_memrd, branch_taken, mdu_start, mem_req, mem_ack}
    localparam logic [4:0] C_IDLE = 5'b00000;
    localparam logic [4:0] C_LD   = 5'b10000;
    localparam logic [4:0] C_BR   = 5'b01000;
    localparam logic [4:0] C_MDU  = 5'b00100;
    localparam logic [4:0] C_REQ  = 5'b00010;
    localparam logic [4:0] C_ACK  = 5'b00001;

    typedef struct {
        string       tag;
        logic [4:0]  en;
        logic [3:0]  bub;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_exp(input string tag, input logic [4:0] en, input logic [3:0] bub,
                            input logic [1:0] st, input int cnt);
        exp_t e;
        e.tag = tag;
        e.en  = en;
        e.bub = bub;
        e.st  = st;
        e.cnt = 16'(cnt);
        sb.push_back(e);
    endtask

    task automatic check_main();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ":en"}, 32'({bus.pc_write_o, bus.ifid_write_o, bus.idex_write_o,
                                 bus.exmem_write_o, bus.memwb_write_o}), 32'(e.en));
        chk({e.tag, ":bub"}, 32'({bus.ifid_flush_o, bus.idex_bubble_o,
                                  bus.exmem_bubble_o, bus.memwb_bubble_o}), 32'(e.bub));
        chk({e.tag, ":state"}, 32'(state_o), 32'(e.st));
        chk({e.tag, ":cnt"}, 32'(stall_cnt_o), 32'(e.cnt));
        chk({e.tag, ":flush_while_stalled"}, 32'(bus.ifid_flush_o & ~bus.pc_write_o), 32'd0);
        if (state_o == 2'd1) chk({e.tag, ":memreq_in_ex_busy"}, 32'(bus.mem_req_i), 32'd0);
    endtask

    task automatic set_regs(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] ifrt);
        bus.idex_rt_i = rt;
        bus.ifid_rs_i = rs;
        bus.ifid_rt_i = ifrt;
    endtask

    task automatic drive(input logic [4:0] ctl);
        {bus.idex_memrd_i, bus.branch_taken_i, bus.mdu_start_i,
         bus.mem_req_i, bus.mem_ack_i} = ctl;
    endtask

    task automatic cyc(input string tag, input logic [4:0] ctl, input logic [4:0] en,
                       input logic [3:0] bub, input logic [1:0] st, input int cnt);
        drive(ctl);
        push_exp(tag, en, bub, st, cnt);
        @(negedge clk_i);
        check_main();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sat_cyc(input string tag, input logic [4:0] en, input int cnt);
        push_exp(tag, en, B_NONE, 2'd0, cnt);
        @(negedge clk_i);
        begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ":en"}, 32'({bus2.pc_write_o, bus2.ifid_write_o, bus2.idex_write_o,
                                     bus2.exmem_write_o, bus2.memwb_write_o}), 32'(e.en));
            chk({e.tag, ":cnt"}, 32'(stall_cnt2), 32'(e.cnt));
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        start_i = 1'b1;
        start2  = 1'b0;
        set_regs(5'd0, 5'd0, 5'd0);
        drive(C_IDLE);
        bus2.idex_memrd_i = 1'b0;  bus2.idex_rt_i = 5'd5;
        bus2.ifid_rs_i = 5'd5;     bus2.ifid_rt_i = 5'd0;
        bus2.branch_taken_i = 1'b0; bus2.mdu_start_i = 1'b0;
        bus2.mem_req_i = 1'b0;     bus2.mem_ack_i = 1'b0;

        #12;
        push_exp("reset", EN_OFF, B_NONE, 2'd0, 0);
        check_main();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        cyc("idle",        C_IDLE, EN_ALL, B_NONE, 2'd0, 0);
        set_regs(5'd5, 5'd5, 5'd0);
        cyc("lu_rs",       C_LD,   EN_LU,  B_LU,   2'd0, 0);
        cyc("no_memrd",    C_IDLE, EN_ALL, B_NONE, 2'd0, 1);
        set_regs(5'd0, 5'd0, 5'd0);
        cyc("lu_rt0",      C_LD,   EN_ALL, B_NONE, 2'd0, 1);
        set_regs(5'd7, 5'd3, 5'd7);
        cyc("lu_rt",       C_LD,   EN_LU,  B_LU,   2'd0, 1);
        cyc("branch",      C_BR,   EN_ALL, B_BR,   2'd0, 2);
        cyc("lu_over_br",  C_LD | C_BR, EN_LU, B_LU, 2'd0, 2);

        cyc("mdu0",        C_MDU,  EN_MDU, B_MDU,  2'd0, 3);
        cyc("mdu1",        C_MDU,  EN_MDU, B_MDU,  2'd1, 4);
        cyc("mdu2",        C_MDU,  EN_MDU, B_MDU,  2'd1, 5);
        cyc("mdu_exit",    C_MDU,  EN_ALL, B_NONE, 2'd1, 6);
        cyc("mdu_done",    C_IDLE, EN_ALL, B_NONE, 2'd0, 6);

        cyc("mw0",         C_REQ,  EN_MEM, B_MEM,  2'd0, 6);
        cyc("mw1",         C_REQ,  EN_MEM, B_MEM,  2'd2, 7);
        cyc("mw2",         C_REQ,  EN_MEM, B_MEM,  2'd2, 8);
        cyc("mw_ack",      C_REQ | C_ACK, EN_ALL, B_NONE, 2'd2, 9);
        cyc("mw_done",     C_IDLE, EN_ALL, B_NONE, 2'd0, 9);
        cyc("ack_first",   C_REQ | C_ACK, EN_ALL, B_NONE, 2'd0, 9);

        set_regs(5'd5, 5'd5, 5'd0);
        cyc("pri0",        C_LD | C_BR | C_MDU | C_REQ, EN_MEM, B_MEM, 2'd0, 9);
        cyc("pri1",        C_LD | C_BR | C_MDU | C_REQ, EN_MEM, B_MEM, 2'd2, 10);
        cyc("pri_ack",     C_LD | C_BR | C_MDU | C_REQ | C_ACK, EN_ALL, B_NONE, 2'd2, 11);
        cyc("pri_mdu0",    C_LD | C_BR | C_MDU, EN_MDU, B_MDU, 2'd0, 11);
        cyc("pri_mdu1",    C_LD | C_BR | C_MDU, EN_MDU, B_MDU, 2'd1, 12);
        cyc("pri_mdu2",    C_LD | C_BR | C_MDU, EN_MDU, B_MDU, 2'd1, 13);
        cyc("pri_exit_lu", C_LD | C_BR | C_MDU, EN_LU,  B_LU,  2'd1, 14);
        cyc("pri_br",      C_BR,   EN_ALL, B_BR,   2'd0, 15);

        cyc("rst_mdu0",    C_MDU,  EN_MDU, B_MDU,  2'd0, 15);
        cyc("rst_mdu1",    C_MDU,  EN_MDU, B_MDU,  2'd1, 16);
        rst_n_i = 1'b0;
        #2;
        push_exp("async_rst", EN_OFF, B_NONE, 2'd0, 0);
        check_main();
        drive(C_IDLE);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cyc("post_rst",    C_IDLE, EN_ALL, B_NONE, 2'd0, 0);

        start_i = 1'b0;
        cyc("start0_mdu",  C_MDU,  EN_OFF, B_NONE, 2'd0, 0);
        cyc("start0_hold", C_MDU | C_LD, EN_OFF, B_NONE, 2'd0, 0);
        start_i = 1'b1;
        cyc("start1_lu",   C_LD,   EN_LU,  B_LU,   2'd0, 0);
        start_i = 1'b0;
        cyc("start0_cnt",  C_LD,   EN_OFF, B_NONE, 2'd0, 1);
        start_i = 1'b1;
        cyc("start1_mdu",  C_MDU,  EN_MDU, B_MDU,  2'd0, 1);
        start_i = 1'b0;
        cyc("start0_ex",   C_MDU,  EN_OFF, B_NONE, 2'd1, 2);
        start_i = 1'b1;
        cyc("ex_resume1",  C_MDU,  EN_MDU, B_MDU,  2'd1, 2);
        cyc("ex_resume2",  C_MDU,  EN_MDU, B_MDU,  2'd1, 3);
        cyc("ex_exit",     C_MDU,  EN_ALL, B_NONE, 2'd1, 4);
        cyc("ex_done",     C_IDLE, EN_ALL, B_NONE, 2'd0, 4);

        bus2.idex_memrd_i = 1'b1;
        sat_cyc("sat_start0", EN_OFF, 0);
        start2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sat_cyc($sformatf("sat_stall%0d", i), EN_LU, (i < 3) ? i : 3);
        end
        bus2.idex_memrd_i = 1'b0;
        sat_cyc("sat_hold", EN_ALL, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
